// File: rtl/ibex_pmp_csr_bank_if.sv
// ibex_pmp_csr_bank_if: single-cycle CSR access bus between the CSR file and the PMP CSR bank
interface ibex_pmp_csr_bank_if;
    logic        csr_access;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_hit;
    logic [31:0] csr_rdata;
    modport master (output csr_access, csr_we, csr_addr, csr_wdata, input csr_hit, csr_rdata);
    modport slave (input csr_access, csr_we, csr_addr, csr_wdata, output csr_hit, csr_rdata);
endinterface

// File: rtl/ibex_pmp_csr_bank.sv
// ibex_pmp_csr_bank: pmpcfg/pmpaddr/mseccfg state with lock, TOR-lock, sticky and WARL rules
module ibex_pmp_csr_bank #(
    parameter int PMPGranularity = 0,
    parameter int PMPNumRegions  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    ibex_pmp_csr_bank_if.slave            bus,
    output logic [PMPNumRegions*6-1:0]    csr_pmp_cfg_o,
    output logic [PMPNumRegions*34-1:0]   csr_pmp_addr_o,
    output logic [2:0]                    csr_pmp_mseccfg_o,
    output logic                          pmp_update_o
);
    localparam int N = PMPNumRegions;
    localparam int G = PMPGranularity;
    localparam logic [31:0] NapotOnes = ~(32'hFFFF_FFFF << (G >= 1 ? G - 1 : 0));
    localparam logic [31:0] LowZero   = ~(32'hFFFF_FFFF << G);

    logic [N-1:0][5:0]  cfg_q, cfg_d, nb;
    logic [N-1:0][31:0] addr_q, addr_d, rd_addr;
    logic [2:0]         msec_q, msec_d;
    logic               update_q;
    logic [N-1:0]       locked, lbit, tor_blk, cfg_ok, addr_ok;
    logic [31:0]        wd;
    logic               wr, cfg_sel, addr_sel, any_l;

    assign wd       = bus.csr_wdata;
    assign wr       = bus.csr_access & bus.csr_we;
    assign cfg_sel  = bus.csr_addr[11:2] == 10'h0E8;
    assign addr_sel = bus.csr_addr[11:4] == 8'h3B;
    assign any_l    = |lbit;
    assign bus.csr_hit = cfg_sel | addr_sel | (bus.csr_addr == 12'h747) | (bus.csr_addr == 12'h757);

    for (genvar r = 0; r < N; r++) begin : g_reg
        localparam int B = 8 * (r % 4);
        assign lbit[r]   = cfg_q[r][5];
        assign locked[r] = cfg_q[r][5] & ~msec_q[2];
        if (r < N - 1) begin : g_tor
            assign tor_blk[r] = locked[r+1] & (cfg_q[r+1][4:3] == 2'b01);
        end else begin : g_last
            assign tor_blk[r] = 1'b0;
        end
        assign nb[r] = {wd[B+7],
                        (G >= 1 && wd[B+4:B+3] == 2'b10) ? 2'b00 : wd[B+4:B+3],
                        wd[B+2],
                        msec_q[0] ? wd[B+1] : wd[B+1] & wd[B],
                        wd[B]};
        assign cfg_ok[r]  = ~locked[r] & ~(msec_q[0] & ~msec_q[2] & (nb[r] != cfg_q[r]) &
                                           nb[r][5] & nb[r][2] & ~(~nb[r][0] & nb[r][1]));
        assign addr_ok[r] = ~locked[r] & ~tor_blk[r];
        assign rd_addr[r] = cfg_q[r][4:3] == 2'b11 ? addr_q[r] | NapotOnes :
                            ~cfg_q[r][4] ? addr_q[r] & ~LowZero : addr_q[r];
        assign csr_pmp_cfg_o[((N-1-r)*6)+:6]    = cfg_q[r];
        assign csr_pmp_addr_o[((N-1-r)*34)+:34] = {addr_q[r], 2'b00};
    end

    assign csr_pmp_mseccfg_o = msec_q;
    assign pmp_update_o      = update_q;

    // Next state: legalised writes applied only where lock rules allow
    always_comb begin
        cfg_d  = cfg_q;
        addr_d = addr_q;
        msec_d = msec_q;
        for (int r = 0; r < N; r++) begin
            if (wr && cfg_sel && bus.csr_addr[1:0] == 2'(r / 4) && cfg_ok[r]) cfg_d[r] = nb[r];
            if (wr && addr_sel && bus.csr_addr[3:0] == 4'(r) && addr_ok[r]) addr_d[r] = wd;
        end
        if (wr && bus.csr_addr == 12'h747)
            msec_d = {(msec_q[2] | ~any_l) ? wd[2] : msec_q[2], msec_q[1:0] | wd[1:0]};
    end

    // Read mux: unimplemented regions, mseccfgh and misses read zero
    always_comb begin
        bus.csr_rdata = '0;
        for (int r = 0; r < N; r++) begin
            if (cfg_sel && bus.csr_addr[1:0] == 2'(r / 4))
                bus.csr_rdata[8*(r%4)+:8] = {cfg_q[r][5], 2'b00, cfg_q[r][4:0]};
            if (addr_sel && bus.csr_addr[3:0] == 4'(r)) bus.csr_rdata = rd_addr[r];
        end
        if (bus.csr_addr == 12'h747) bus.csr_rdata = {29'b0, msec_q};
    end

    // State registers; update pulses when any stored bit changes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_q    <= '0;
            addr_q   <= '0;
            msec_q   <= '0;
            update_q <= 1'b0;
        end else begin
            cfg_q    <= cfg_d;
            addr_q   <= addr_d;
            msec_q   <= msec_d;
            update_q <= {cfg_d, addr_d, msec_d} != {cfg_q, addr_q, msec_q};
        end
    end
endmodule

// File: tb/tb_ibex_pmp_csr_bank.sv
// tb_ibex_pmp_csr_bank: directed checks of the PMP CSR bank at granularity 0 and 2
module tb_ibex_pmp_csr_bank;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ibex_pmp_csr_bank_if b0 ();
    ibex_pmp_csr_bank_if b2 ();
    logic [23:0]  cfg0, cfg2;
    logic [135:0] ad0, ad2;
    logic [2:0]   ms0, ms2;
    logic         up0, up2;
    int errors = 0;
    int checks = 0;

    ibex_pmp_csr_bank #(.PMPGranularity(0), .PMPNumRegions(4)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .bus(b0), .csr_pmp_cfg_o(cfg0),
        .csr_pmp_addr_o(ad0), .csr_pmp_mseccfg_o(ms0), .pmp_update_o(up0));
    ibex_pmp_csr_bank #(.PMPGranularity(2), .PMPNumRegions(4)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .bus(b2), .csr_pmp_cfg_o(cfg2),
        .csr_pmp_addr_o(ad2), .csr_pmp_mseccfg_o(ms2), .pmp_update_o(up2));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        b0.csr_access = 0; b0.csr_we = 0; b0.csr_addr = '0; b0.csr_wdata = '0;
        b2.csr_access = 0; b2.csr_we = 0; b2.csr_addr = '0; b2.csr_wdata = '0;
    endtask

    task automatic wr(input bit s, input logic [11:0] a, input logic [31:0] d);
        if (s) begin
            b2.csr_access = 1; b2.csr_we = 1; b2.csr_addr = a; b2.csr_wdata = d;
        end else begin
            b0.csr_access = 1; b0.csr_we = 1; b0.csr_addr = a; b0.csr_wdata = d;
        end
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rd(input bit s, input logic [11:0] a, input logic [31:0] exp, input string tag);
        @(negedge clk);
        if (s) begin
            b2.csr_access = 1; b2.csr_addr = a;
        end else begin
            b0.csr_access = 1; b0.csr_addr = a;
        end
        #1;
        chk(tag, s ? b2.csr_rdata : b0.csr_rdata, exp);
        idle();
    endtask

    task automatic hit(input logic [11:0] a, input logic exp, input string tag);
        @(negedge clk);
        b0.csr_addr = a;
        #1;
        chk(tag, b0.csr_hit, exp);
        idle();
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        // reset state
        rd(0, 12'h3A0, 32'h0, "rst_cfg0");
        rd(0, 12'h3B0, 32'h0, "rst_addr0");
        rd(0, 12'h747, 32'h0, "rst_msec");
        chk("rst_cfg_o", cfg0, 24'h0);
        chk("rst_addr_o", ad0[63:0], 64'h0);
        chk("rst_msec_o", ms0, 3'b000);
        chk("rst_update", up0, 1'b0);
        chk("rst_cfg_o_g2", cfg2, 24'h0);
        hit(12'h3A0, 1'b1, "hit_3a0");
        hit(12'h300, 1'b0, "miss_300");
        rd(0, 12'h300, 32'h0, "miss_rdata");
        // plain writes
        wr(0, 12'h3A0, 32'h0000_001F);
        chk("cfg0_1f", cfg0[23:18], 6'b011111);
        chk("upd_cfg0", up0, 1'b1);
        @(posedge clk); #1;
        chk("upd_one_cycle", up0, 1'b0);
        wr(0, 12'h3B0, 32'h2000_0000);
        chk("addr0_o", ad0[135:102], 34'h0_8000_0000);
        chk("upd_addr0", up0, 1'b1);
        rd(0, 12'h3B0, 32'h2000_0000, "rd_addr0");
        wr(0, 12'h3A0, 32'h0000_001F);
        chk("upd_same_data", up0, 1'b0);
        // lock region0
        wr(0, 12'h3A0, 32'h0000_0099);
        chk("cfg0_locked", cfg0[23:18], 6'b111001);
        wr(0, 12'h3B0, 32'h0000_1234);
        chk("upd_locked_addr", up0, 1'b0);
        chk("addr0_kept", ad0[135:102], 34'h0_8000_0000);
        wr(0, 12'h3A0, 32'h0);
        chk("upd_locked_cfg", up0, 1'b0);
        chk("cfg0_kept", cfg0[23:18], 6'b111001);
        // TOR lock
        wr(0, 12'h3A0, 32'h0000_8800);
        chk("cfg1_tor", cfg0[17:12], 6'b101000);
        wr(0, 12'h3B2, 32'h0000_5555);
        rd(0, 12'h3B2, 32'h0000_5555, "addr2_ok");
        wr(0, 12'h3A0, 32'h8800_0000);
        chk("cfg3_tor", cfg0[5:0], 6'b101000);
        wr(0, 12'h3B2, 32'h0000_AAAA);
        chk("upd_tor_lock", up0, 1'b0);
        rd(0, 12'h3B2, 32'h0000_5555, "addr2_torlocked");
        rd(0, 12'h3A0, 32'h8800_8899, "rd_cfg_all");
        // mseccfg sticky bits and RLB guard
        wr(0, 12'h747, 32'h7);
        chk("msec_011", ms0, 3'b011);
        chk("upd_msec", up0, 1'b1);
        wr(0, 12'h747, 32'h0);
        chk("msec_sticky", ms0, 3'b011);
        rd(0, 12'h747, 32'h3, "rd_msec");
        // MML: new locked executable region refused, shared encoding accepted
        wr(0, 12'h3A0, 32'h0084_0000);
        chk("mml_refuse", cfg0[11:6], 6'b000000);
        wr(0, 12'h3A0, 32'h0086_0000);
        chk("mml_shared", cfg0[11:6], 6'b100110);
        // reset mid-stream clears a pending pulse
        rst_n = 1'b0;
        #1;
        chk("midrst_upd", up0, 1'b0);
        chk("midrst_cfg", cfg0, 24'h0);
        chk("midrst_msec", ms0, 3'b000);
        #1 rst_n = 1'b1;
        // RLB lets locked regions be edited
        wr(0, 12'h747, 32'h4);
        chk("rlb_set", ms0, 3'b100);
        wr(0, 12'h3A0, 32'h0000_0099);
        wr(0, 12'h3B0, 32'h0000_1234);
        rd(0, 12'h3B0, 32'h0000_1234, "rlb_addr_write");
        wr(0, 12'h747, 32'h0);
        chk("rlb_clear", ms0, 3'b000);
        wr(0, 12'h3B0, 32'h0000_5678);
        rd(0, 12'h3B0, 32'h0000_1234, "relocked_addr");
        wr(0, 12'h747, 32'h4);
        chk("rlb_refused", ms0, 3'b000);
        // W without R is stored as W=0 when MML=0
        wr(0, 12'h3A0, 32'h0000_0200);
        chk("w_only_upd", up0, 1'b0);
        chk("w_only", cfg0[17:12], 6'b000000);
        wr(0, 12'h3A0, 32'h0000_0300);
        chk("rw", cfg0[17:12], 6'b000011);
        wr(0, 12'h3A0, 32'h0000_0200);
        chk("w_only_again", cfg0[17:12], 6'b000000);
        chk("w_only_upd2", up0, 1'b1);
        // idle bus with we=1 changes nothing
        b0.csr_we = 1; b0.csr_addr = 12'h3B1; b0.csr_wdata = 32'hFFFF;
        @(posedge clk); #1;
        idle();
        chk("noaccess_upd", up0, 1'b0);
        rd(0, 12'h3B1, 32'h0, "noaccess_addr1");
        // unimplemented and mseccfgh
        wr(0, 12'h3B4, 32'hFFFF_FFFF);
        chk("unimpl_upd", up0, 1'b0);
        rd(0, 12'h3B4, 32'h0, "unimpl_rd");
        hit(12'h3B4, 1'b1, "unimpl_hit");
        rd(0, 12'h3A1, 32'h0, "cfg1_unimpl_rd");
        wr(0, 12'h757, 32'h7);
        chk("msech_upd", up0, 1'b0);
        rd(0, 12'h757, 32'h0, "msech_rd");
        hit(12'h757, 1'b1, "msech_hit");
        // granularity 2
        wr(1, 12'h3A0, 32'h0000_0010);
        chk("g2_na4_off", cfg2[23:18], 6'b000000);
        rd(1, 12'h3A0, 32'h0, "g2_na4_rd");
        wr(1, 12'h3A0, 32'h0000_0018);
        chk("g2_napot", cfg2[23:18], 6'b011000);
        wr(1, 12'h3B0, 32'h0);
        rd(1, 12'h3B0, 32'h1, "g2_napot_rd");
        chk("g2_napot_o", ad2[135:102], 34'h0);
        wr(1, 12'h3B0, 32'hF);
        rd(1, 12'h3B0, 32'hF, "g2_napot_rdF");
        wr(1, 12'h3A0, 32'h0000_0008);
        rd(1, 12'h3B0, 32'hC, "g2_tor_rd");
        chk("g2_tor_o", ad2[135:102], 34'h3C);
        rd(1, 12'h3A0, 32'h8, "g2_tor_cfg_rd");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
